// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and limits for the bit-serial adder
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} sadd_state_t;
    localparam int SADD_MAX_WIDTH = 64;
endpackage

// File: rtl/fa_bit.sv
// fa_bit: combinational 1-bit full adder, the single arithmetic cell reused every ADD cycle
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add done LSB first through one shared full-adder cell
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sadd_state_t      state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c, last;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_s),
        .carry(fa_c)
    );

    assign last = cnt == CW'(WIDTH - 1);

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // next state: accept only in IDLE, finish on the last bit, release on the output handshake
    always_comb
        state_nx = (state == IDLE && in_valid)  ? ADD  :
                   (state == ADD  && last)      ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;

    // handshake and status outputs decode directly from the state register
    always_comb begin
        in_ready  = state == IDLE;
        busy      = state == ADD;
        out_valid = state == DONE;
    end

    // datapath: load operands on accept, then shift one bit through the cell per ADD cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            sum   <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            if (last) cout <= fa_c;
        end
endmodule
